cursor_ctrl: RTL

//   Produces the cursor position consumed by the cursor overlay renderer.
//   - Takes five raw board push-buttons (up/down/left/right/select) and synchronises and debounces each one.
//   - Turns each debounced press into a move of the cursor on a COLS x ROWS grid of CELL-pixel cells.
//   - Publishes the top-left pixel position of the cursor, updated only on frame_tick so the cursor never tears mid-frame.

---
 rtl/cursor_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cursor_ctrl.sv
// Cursor position controller: synchronises and debounces five push-buttons,
// moves a cursor on a COLS x ROWS cell grid and publishes its top-left pixel
// position once per frame so the overlay never tears.
module cursor_ctrl #(
  parameter int CELL      = 32,
  parameter int COLS      = 20,
  parameter int ROWS      = 15,
  parameter int X_ORG     = 0,
  parameter int Y_ORG     = 0,
  parameter int DB_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       frame_tick,
  output logic [9:0] top_left_x,
  output logic [9:0] top_left_y,
  output logic [4:0] cell_col,
  output logic [4:0] cell_row,
  output logic       sel_pulse
);

  localparam int unsigned NB = 5;
  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam int unsigned SH = $clog2(CELL);
  localparam logic [4:0] COL_MAX = 5'(COLS - 1);
  localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);

  // Button indices: 0 up, 1 down, 2 left, 3 right, 4 select
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    HIGH    = 2'd2,
    WAIT_LO = 2'd3
  } db_state_e;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1_q, sync2_q;
  db_state_e     state_q [NB];
  db_state_e     state_d [NB];
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  logic [NB-1:0] press;

  logic [4:0] col_q, col_d, row_q, row_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       sel_q;

  assign raw = {btn_sel, btn_right, btn_left, btn_down, btn_up};

  // Two-flop synchroniser on every raw button
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce state and counter registers, one pair per button
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NB; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Debounce next-state: press fires on the cycle a high level is accepted
  always_comb begin
    press = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = WAIT_HI;
            cnt_d[i]   = '0;
          end
        end
        WAIT_HI: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = HIGH;
            cnt_d[i]   = '0;
            press[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        HIGH: begin
          if (!sync2_q[i]) begin
            state_d[i] = WAIT_LO;
            cnt_d[i]   = '0;
          end
        end
        WAIT_LO: begin
          if (sync2_q[i]) begin
            state_d[i] = HIGH;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Cursor move with wrap-around; opposing presses on one axis cancel
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (press[0] && !press[1]) row_d = (row_q == 5'd0)    ? ROW_MAX : row_q - 5'd1;
    if (press[1] && !press[0]) row_d = (row_q == ROW_MAX) ? 5'd0    : row_q + 5'd1;
    if (press[2] && !press[3]) col_d = (col_q == 5'd0)    ? COL_MAX : col_q - 5'd1;
    if (press[3] && !press[2]) col_d = (col_q == COL_MAX) ? 5'd0    : col_q + 5'd1;
  end

  // Pixel position of the current (pre-move) cell; CELL is a power of two
  always_comb begin
    x_d = 10'(X_ORG) + (10'(col_q) << SH);
    y_d = 10'(Y_ORG) + (10'(row_q) << SH);
  end

  // Cell registers, select pulse and frame-synchronous position publish
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
      sel_q <= 1'b0;
      x_q   <= 10'(X_ORG);
      y_q   <= 10'(Y_ORG);
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      sel_q <= press[4];
      if (frame_tick) begin
        x_q <= x_d;
        y_q <= y_d;
      end
    end
  end

  assign cell_col   = col_q;
  assign cell_row   = row_q;
  assign sel_pulse  = sel_q;
  assign top_left_x = x_q;
  assign top_left_y = y_q;

endmodule
